// File: rtl/reaction_timer_mp.sv
// reaction_timer_mp: multi-player reaction timer with random wait, BCD ms timing, fouls, winner and best-time records
module reaction_timer_mp #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int PLAYERS      = 2,
    parameter int DIGITS       = 4,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_STEPS  = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PLAYERS-1:0]          stop,
    input  logic                        clear_record,
    output logic [PLAYERS*4*DIGITS-1:0] result_bcd,
    output logic [PLAYERS*4*DIGITS-1:0] best_bcd,
    output logic [PLAYERS-1:0]          foul,
    output logic [2:0]                  winner,
    output logic                        winner_valid,
    output logic [1:0]                  phase,
    output logic                        led
);
    localparam int W = 4 * DIGITS;
    localparam int DIV = CLK_HZ / 1000;
    localparam int PW = $clog2(DIV + 1);
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};
    typedef enum logic [1:0] {IDLE, WAIT, TIMING, RESULT} state_t;
    state_t state, state_n;
    logic [7:0] lfsr;
    logic [PW-1:0] presc;
    logic [31:0] wait_cnt, target, delay_ms;
    logic [PLAYERS-1:0] stopped, active, lock_now, cand, at9;
    logic tick, go, expire, sat, to_result, enter_timed, win_ok;
    logic [2:0] win_idx;
    logic [W-1:0] win_val;
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
                else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction
    assign tick        = presc == PW'(DIV - 1);
    assign go          = !start && (state == IDLE || state == RESULT);
    assign delay_ms    = 32'(MIN_DELAY_MS) + 32'd1000 * (32'(lfsr) % 32'(DELAY_STEPS));
    assign expire      = state == WAIT && tick && (wait_cnt + 32'd1 >= target);
    assign active      = ~foul & ~stopped;
    assign lock_now    = state == TIMING ? active & ~stop : '0;
    assign cand        = stopped | lock_now;
    assign sat         = state == TIMING && tick && |(active & at9);
    assign to_result   = state_n == RESULT && state != RESULT;
    assign enter_timed = (state_n == WAIT || state_n == TIMING) && state_n != state;
    assign phase       = state;
    assign led         = state == TIMING;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? WAIT : IDLE;
            WAIT:    state_n = &(foul | ~stop) ? RESULT : (expire ? TIMING : WAIT);
            TIMING:  state_n = (&(foul | stopped | ~stop) || sat) ? RESULT : TIMING;
            default: state_n = go ? WAIT : RESULT;
        endcase
    end
    // Lowest index wins ties because only a strictly smaller value replaces the leader
    always_comb begin
        at9     = '0;
        win_idx = '0;
        win_ok  = 1'b0;
        win_val = ALL9;
        for (int p = 0; p < PLAYERS; p++) begin
            at9[p] = result_bcd[p*W +: W] == ALL9;
            if (cand[p] && (!win_ok || result_bcd[p*W +: W] < win_val)) begin
                win_idx = 3'(p);
                win_ok  = 1'b1;
                win_val = result_bcd[p*W +: W];
            end
        end
    end
    always_ff @(posedge clk) state <= reset ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= 8'h01;
            presc        <= '0;
            wait_cnt     <= '0;
            target       <= '0;
            result_bcd   <= '0;
            best_bcd     <= {PLAYERS{ALL9}};
            foul         <= '0;
            stopped      <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
        end else begin
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            presc <= (tick || enter_timed) ? '0 : presc + 1'b1;
            if (go) begin
                target       <= delay_ms;
                wait_cnt     <= '0;
                result_bcd   <= '0;
                foul         <= '0;
                stopped      <= '0;
                winner_valid <= 1'b0;
            end
            if (state == WAIT && tick) wait_cnt <= wait_cnt + 32'd1;
            for (int p = 0; p < PLAYERS; p++) begin
                if (state == WAIT && !stop[p]) begin
                    foul[p]              <= 1'b1;
                    result_bcd[p*W +: W] <= ALL9;
                end
                // A stop in a tick cycle keeps the pre-increment value
                if (state == TIMING && active[p]) begin
                    if (!stop[p]) stopped[p] <= 1'b1;
                    else if (sat) result_bcd[p*W +: W] <= ALL9;
                    else if (tick) result_bcd[p*W +: W] <= bcd_inc(result_bcd[p*W +: W]);
                end
            end
            if (to_result) begin
                winner       <= win_idx;
                winner_valid <= win_ok;
                for (int p = 0; p < PLAYERS; p++)
                    if (cand[p] && result_bcd[p*W +: W] < best_bcd[p*W +: W])
                        best_bcd[p*W +: W] <= result_bcd[p*W +: W];
            end
            if (clear_record) best_bcd <= {PLAYERS{ALL9}};
        end
    end
endmodule

// File: tb/tb_reaction_timer_mp.sv
// tb_reaction_timer_mp: table-driven rounds with a scoreboard queue, plus reset, clear and saturation sequences
module tb_reaction_timer_mp;
    localparam int MIN_MS = 1000;
    localparam int STEPS  = 3;
    localparam int BUDGET = 4000;
    typedef struct {
        int          s0, s1;
        logic [1:0]  fmask;
        logic [15:0] r0, r1, b0, b1;
        logic [1:0]  foul;
        logic [2:0]  win;
        logic        valid;
    } vec_t;
    logic clk = 1'b0;
    logic rst_a, rst_b, sel, start_v, clear_v;
    logic [1:0] stop_v;
    logic start_a, start_b, clear_a, clear_b;
    logic [1:0] stop_a, stop_b;
    logic [31:0] res_a, best_a;
    logic [15:0] res_b, best_b;
    logic [1:0] foul_a, foul_b, phase_a, phase_b;
    logic [2:0] win_a, win_b;
    logic valid_a, valid_b, led_a, led_b;
    logic [7:0] lfsr_a, lfsr_b;
    logic [15:0] cur_r0, cur_r1, cur_b0, cur_b1;
    logic [1:0] cur_phase, cur_foul;
    logic [2:0] cur_win;
    logic cur_valid, cur_led;
    logic [7:0] cur_lfsr;
    int checks = 0, errors = 0, rnd = 0, led_cnt = 0;
    vec_t vec_a[6];
    vec_t vec_b[2];
    vec_t sb[$];
    reaction_timer_mp #(.CLK_HZ(1000), .PLAYERS(2), .DIGITS(4), .MIN_DELAY_MS(MIN_MS), .DELAY_STEPS(STEPS)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .stop(stop_a), .clear_record(clear_a),
        .result_bcd(res_a), .best_bcd(best_a), .foul(foul_a), .winner(win_a),
        .winner_valid(valid_a), .phase(phase_a), .led(led_a));
    reaction_timer_mp #(.CLK_HZ(1000), .PLAYERS(2), .DIGITS(2), .MIN_DELAY_MS(MIN_MS), .DELAY_STEPS(STEPS)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .stop(stop_b), .clear_record(clear_b),
        .result_bcd(res_b), .best_bcd(best_b), .foul(foul_b), .winner(win_b),
        .winner_valid(valid_b), .phase(phase_b), .led(led_b));
    always #5 clk = ~clk;
    assign start_a   = sel ? 1'b1 : start_v;
    assign start_b   = sel ? start_v : 1'b1;
    assign stop_a    = sel ? 2'b11 : stop_v;
    assign stop_b    = sel ? stop_v : 2'b11;
    assign clear_a   = sel ? 1'b0 : clear_v;
    assign clear_b   = sel ? clear_v : 1'b0;
    assign cur_r0    = sel ? {8'h00, res_b[7:0]} : res_a[15:0];
    assign cur_r1    = sel ? {8'h00, res_b[15:8]} : res_a[31:16];
    assign cur_b0    = sel ? {8'h00, best_b[7:0]} : best_a[15:0];
    assign cur_b1    = sel ? {8'h00, best_b[15:8]} : best_a[31:16];
    assign cur_phase = sel ? phase_b : phase_a;
    assign cur_foul  = sel ? foul_b : foul_a;
    assign cur_win   = sel ? win_b : win_a;
    assign cur_valid = sel ? valid_b : valid_a;
    assign cur_led   = sel ? led_b : led_a;
    assign cur_lfsr  = sel ? lfsr_b : lfsr_a;
    // Reference x^8+x^6+x^5+x^4+1 sequence, used to predict each random wait
    always @(posedge clk) begin
        lfsr_a <= rst_a ? 8'h01 : {lfsr_a[6:0], lfsr_a[7] ^ lfsr_a[5] ^ lfsr_a[4] ^ lfsr_a[3]};
        lfsr_b <= rst_b ? 8'h01 : {lfsr_b[6:0], lfsr_b[7] ^ lfsr_b[5] ^ lfsr_b[4] ^ lfsr_b[3]};
    end
    always @(negedge clk) if (cur_led) led_cnt++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (round %0d): got %h expected %h", name, rnd, act, exp);
        end
    endtask
    task automatic run_round(input vec_t v);
        int n, m, tgt, l0;
        vec_t e;
        @(negedge clk);
        tgt = MIN_MS + 1000 * (int'(cur_lfsr) % STEPS);
        sb.push_back(v);
        l0 = led_cnt;
        m = 0;
        start_v = 1'b0;
        n = 0;
        @(negedge clk);
        n++;
        start_v = 1'b1;
        chk("enter_wait", 32'(cur_phase), 32'd1);
        if (v.fmask != 2'b00) begin
            stop_v = ~v.fmask;
            @(negedge clk);
            n++;
            stop_v = 2'b11;
        end
        if (v.fmask != 2'b11) begin
            while (cur_phase != 2'd2 && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            chk("wait_len", 32'(n), 32'(tgt + 1));
            while (cur_phase == 2'd2 && m < 3 * BUDGET) begin
                if (v.s0 == m) stop_v[0] = 1'b0;
                if (v.s1 == m) stop_v[1] = 1'b0;
                @(negedge clk);
                m++;
            end
        end
        stop_v = 2'b11;
        chk("enter_result", 32'(cur_phase), 32'd3);
        chk("led_cycles", 32'(led_cnt - l0), 32'(m));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result0", 32'(cur_r0), 32'(e.r0));
            chk("result1", 32'(cur_r1), 32'(e.r1));
            chk("foul", 32'(cur_foul), 32'(e.foul));
            chk("winner", 32'(cur_win), 32'(e.win));
            chk("winner_valid", 32'(cur_valid), 32'(e.valid));
            chk("best0", 32'(cur_b0), 32'(e.b0));
            chk("best1", 32'(cur_b1), 32'(e.b1));
        end
    endtask
    initial begin
        int n;
        vec_a[0] = '{40, -1, 2'b10, 16'h0040, 16'h9999, 16'h0040, 16'h9999, 2'b10, 3'd0, 1'b1};
        vec_a[1] = '{-1, -1, 2'b11, 16'h9999, 16'h9999, 16'h0040, 16'h9999, 2'b11, 3'd0, 1'b0};
        vec_a[2] = '{123, 250, 2'b00, 16'h0123, 16'h0250, 16'h0040, 16'h0250, 2'b00, 3'd0, 1'b1};
        vec_a[3] = '{77, 77, 2'b00, 16'h0077, 16'h0077, 16'h0077, 16'h0077, 2'b00, 3'd0, 1'b1};
        vec_a[4] = '{60, 90, 2'b00, 16'h0060, 16'h0090, 16'h0060, 16'h0077, 2'b00, 3'd0, 1'b1};
        vec_a[5] = '{30, 12, 2'b00, 16'h0030, 16'h0012, 16'h0030, 16'h0012, 2'b00, 3'd1, 1'b1};
        vec_b[0] = '{50, 70, 2'b00, 16'h0050, 16'h0070, 16'h0050, 16'h0070, 2'b00, 3'd0, 1'b1};
        vec_b[1] = '{-1, -1, 2'b00, 16'h0099, 16'h0099, 16'h0050, 16'h0070, 2'b00, 3'd0, 1'b0};
        rst_a = 1'b1;
        rst_b = 1'b1;
        sel = 1'b0;
        start_v = 1'b1;
        stop_v = 2'b11;
        clear_v = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("rst_phase", 32'(phase_a), 32'd0);
        chk("rst_led", 32'(led_a), 32'd0);
        chk("rst_result", res_a, 32'd0);
        chk("rst_best", best_a, 32'h99999999);
        chk("rst_foul", 32'(foul_a), 32'd0);
        chk("rst_winner", 32'({win_a, valid_a}), 32'd0);
        chk("rst_best_b", 32'(best_b), 32'h9999);
        for (int i = 0; i < 6; i++) begin
            rnd = i;
            run_round(vec_a[i]);
            if (i == 2) begin
                @(negedge clk);
                clear_v = 1'b1;
                @(negedge clk);
                clear_v = 1'b0;
                chk("clear_best", best_a, 32'h99999999);
                chk("clear_phase", 32'(phase_a), 32'd3);
            end
        end
        rnd = 100;
        @(negedge clk);
        start_v = 1'b0;
        @(negedge clk);
        start_v = 1'b1;
        n = 0;
        while (phase_a != 2'd2 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("reach_timing", 32'(phase_a), 32'd2);
        repeat (20) @(negedge clk);
        chk("timing_count", res_a, 32'h00200020);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("midrst_phase", 32'(phase_a), 32'd0);
        chk("midrst_led", 32'(led_a), 32'd0);
        chk("midrst_best", best_a, 32'h99999999);
        chk("midrst_result", res_a, 32'd0);
        chk("midrst_valid", 32'(valid_a), 32'd0);
        sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rnd = 200 + i;
            run_round(vec_b[i]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
